clk_en_gen: RTL and testbench

- Programmable clock-enable / divided-clock generator that sits directly upstream of the synchronous up-counter and drives its enable input with a one-cycle tick every N cycles.
- Also produces a registered, near-50%-duty divided clock (clk_out) for distribution experiments.
- The divide ratio is updated through a valid/ready port. Updates take effect only on period boundaries, so tick spacing and clk_out never glitch or truncate.

---
 rtl/clk_en_gen_if.sv | 24 ++
 rtl/clk_en_gen.sv | 113 +++++++++++
 tb/tb_clk_en_gen.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/clk_en_gen_if.sv
// Divide-ratio update port: div_val/div_load valid-ready transfer plus a zero-value error pulse.
// The master drives the request; the generator answers with div_ready and div_err.
interface clk_en_gen_if #(
    parameter int DIV_WIDTH = 8
);
    logic [DIV_WIDTH-1:0] div_val;
    logic                 div_load;
    logic                 div_ready;
    logic                 div_err;

    modport master (
        output div_val,
        output div_load,
        input  div_ready,
        input  div_err
    );

    modport slave (
        input  div_val,
        input  div_load,
        output div_ready,
        output div_err
    );
endinterface

// File: rtl/clk_en_gen.sv
// Clock-enable generator: one-cycle tick every N cycles plus a registered ~50% divided clock.
// Outputs are flops aligned with the phase they describe; ratio updates are held until a period boundary.
module clk_en_gen #(
    parameter int DIV_WIDTH   = 8,
    parameter int DEFAULT_DIV = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         run,
    clk_en_gen_if.slave  cfg,
    output logic         tick,
    output logic         clk_out,
    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t               state, state_nx;
    logic [DIV_WIDTH-1:0] phase, phase_nx;
    logic [DIV_WIDTH-1:0] div, div_nx;
    logic [DIV_WIDTH-1:0] pend_val, pend_val_nx;
    logic                 pend_vld, pend_vld_nx;
    logic                 err_nx;
    logic                 tick_nx, clk_out_nx;
    logic                 wrap, apply, accept, active_nx;
    logic [DIV_WIDTH:0]   half_nx;

    assign cfg.div_ready = ~pend_vld;

    always_comb begin
        state_nx    = state;
        phase_nx    = phase;
        div_nx      = div;
        pend_val_nx = pend_val;
        pend_vld_nx = pend_vld;
        err_nx      = 1'b0;
        apply       = 1'b0;
        wrap        = (phase == (div - DIV_WIDTH'(1)));

        case (state)
            IDLE: begin
                phase_nx = '0;
                apply    = 1'b1;
                if (run) state_nx = RUN;
            end
            RUN: begin
                phase_nx = wrap ? '0 : phase + DIV_WIDTH'(1);
                apply    = wrap;
                if (!run) state_nx = DRAIN;
            end
            DRAIN: begin
                phase_nx = wrap ? '0 : phase + DIV_WIDTH'(1);
                apply    = wrap;
                if (run)       state_nx = RUN;
                else if (wrap) state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
                phase_nx = '0;
            end
        endcase

        if (apply && pend_vld) begin
            div_nx      = pend_val;
            pend_vld_nx = 1'b0;
        end

        // Accept needs an empty slot and apply needs a full one, so they never collide.
        accept = cfg.div_load && !pend_vld;
        if (accept) begin
            if (cfg.div_val == '0) begin
                err_nx = 1'b1;
            end else begin
                pend_vld_nx = 1'b1;
                pend_val_nx = cfg.div_val;
            end
        end

        active_nx  = (state_nx != IDLE);
        half_nx    = ({1'b0, div_nx} + (DIV_WIDTH+1)'(1)) >> 1;
        tick_nx    = active_nx && (phase_nx == '0);
        clk_out_nx = active_nx && ({1'b0, phase_nx} < half_nx);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            phase    <= '0;
            div      <= DIV_WIDTH'(DEFAULT_DIV);
            pend_val <= '0;
            pend_vld <= 1'b0;
            tick     <= 1'b0;
            clk_out  <= 1'b0;
            busy     <= 1'b0;
            cfg.div_err <= 1'b0;
        end else begin
            state    <= state_nx;
            phase    <= phase_nx;
            div      <= div_nx;
            pend_val <= pend_val_nx;
            pend_vld <= pend_vld_nx;
            tick     <= tick_nx;
            clk_out  <= clk_out_nx;
            busy     <= active_nx;
            cfg.div_err <= err_nx;
        end
    end

endmodule

// File: tb/tb_clk_en_gen.sv
// Bench for clk_en_gen: directed scenarios with fixed expectations, then random traffic
// compared cycle by cycle against a period-level reference model.
module tb_clk_en_gen;
    localparam int W = 8;

    logic clk, rst_n, run, tick, clk_out, busy;
    clk_en_gen_if #(.DIV_WIDTH(W)) dif();

    clk_en_gen #(.DIV_WIDTH(W), .DEFAULT_DIV(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .run     (run),
        .cfg     (dif),
        .tick    (tick),
        .clk_out (clk_out),
        .busy    (busy)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: "on" while generating, "stop" once run has been seen low, position in period.
    bit m_on, m_stop, m_err;
    int m_pos, m_n;
    int m_pq[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic model_reset();
        m_on = 0; m_stop = 0; m_err = 0; m_pos = 0; m_n = 4;
        m_pq.delete();
    endtask

    task automatic model_step(input bit r, input bit ld, input int v);
        bit rdy;
        rdy = (m_pq.size() == 0);
        if (!m_on) begin
            if (!rdy) m_n = m_pq.pop_front();
            m_pos = 0;
            if (r) begin m_on = 1; m_stop = 0; end
        end else if (m_pos == m_n - 1) begin
            m_pos = 0;
            if (!rdy) m_n = m_pq.pop_front();
            if (m_stop && !r) m_on = 0;
            m_stop = m_on && !r;
        end else begin
            m_pos++;
            m_stop = !r;
        end
        m_err = ld && rdy && (v == 0);
        if (ld && rdy && v != 0) m_pq.push_back(v);
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step(run, dif.div_load, int'(dif.div_val));
        #1;
    endtask

    task automatic load_idle(input int v);
        dif.div_load = 1'b1;
        dif.div_val  = W'(v);
        cyc();
        dif.div_load = 1'b0;
        cyc();
    endtask

    task automatic to_idle();
        int k;
        run = 1'b0;
        k = 0;
        while (busy && k < 600) begin cyc(); k++; end
        n_chk++; if (busy !== 1'b0) $display("FAIL to_idle busy=%b required 0 after %0d cycles", busy, k); else n_pass++;
        n_chk++; if ({tick, clk_out} !== 2'b00) $display("FAIL to_idle tick/clk_out=%b required 00", {tick, clk_out}); else n_pass++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; run = 1'b0; dif.div_load = 1'b0; dif.div_val = '0;
        model_reset();
        #7;
        n_chk++; if (tick !== 1'b0)          $display("FAIL reset tick=%b required 0", tick); else n_pass++;
        n_chk++; if (clk_out !== 1'b0)       $display("FAIL reset clk_out=%b required 0", clk_out); else n_pass++;
        n_chk++; if (busy !== 1'b0)          $display("FAIL reset busy=%b required 0", busy); else n_pass++;
        n_chk++; if (dif.div_err !== 1'b0)   $display("FAIL reset div_err=%b required 0", dif.div_err); else n_pass++;
        n_chk++; if (dif.div_ready !== 1'b1) $display("FAIL reset div_ready=%b required 1", dif.div_ready); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        n_chk++; if (busy !== 1'b0) $display("FAIL reset_idle busy=%b required 0", busy); else n_pass++;
    endtask

    task automatic test_default_run();
        int ph;
        run = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            cyc();
            ph = (c - 1) % 4;
            n_chk++; if (tick !== (ph == 0))   $display("FAIL default c=%0d tick=%b required %b", c, tick, ph == 0); else n_pass++;
            n_chk++; if (clk_out !== (ph < 2)) $display("FAIL default c=%0d clk_out=%b required %b", c, clk_out, ph < 2); else n_pass++;
            n_chk++; if (busy !== 1'b1)        $display("FAIL default c=%0d busy=%b required 1", c, busy); else n_pass++;
        end
        to_idle();
    endtask

    task automatic test_update();
        int ph, n;
        run = 1'b1;
        cyc(); cyc();
        dif.div_load = 1'b1; dif.div_val = W'(3);
        cyc();
        dif.div_load = 1'b0;
        for (int c = 3; c <= 14; c++) begin
            if (c > 3) cyc();
            if (c <= 4) begin ph = c - 1; n = 4; end
            else begin ph = (c - 5) % 3; n = 3; end
            n_chk++; if (tick !== (ph == 0)) $display("FAIL update c=%0d tick=%b required %b", c, tick, ph == 0); else n_pass++;
            n_chk++; if (clk_out !== (ph < (n + 1) / 2)) $display("FAIL update c=%0d clk_out=%b required %b", c, clk_out, ph < (n + 1) / 2); else n_pass++;
            n_chk++; if (dif.div_ready !== (c >= 5)) $display("FAIL update c=%0d div_ready=%b required %b", c, dif.div_ready, c >= 5); else n_pass++;
        end
        to_idle();
        load_idle(4);
    endtask

    task automatic test_zero();
        run = 1'b1;
        cyc(); cyc();
        dif.div_load = 1'b1; dif.div_val = '0;
        cyc();
        dif.div_load = 1'b0;
        for (int c = 3; c <= 13; c++) begin
            if (c > 3) cyc();
            n_chk++; if (dif.div_err !== (c == 3)) $display("FAIL zero c=%0d div_err=%b required %b", c, dif.div_err, c == 3); else n_pass++;
            n_chk++; if (dif.div_ready !== 1'b1)   $display("FAIL zero c=%0d div_ready=%b required 1", c, dif.div_ready); else n_pass++;
            n_chk++; if (tick !== ((c - 1) % 4 == 0)) $display("FAIL zero c=%0d tick=%b required %b", c, tick, (c - 1) % 4 == 0); else n_pass++;
        end
        to_idle();
    endtask

    task automatic test_drain();
        logic [4:0] pat;
        load_idle(5);
        run = 1'b1;
        cyc(); pat[4] = clk_out;
        cyc(); pat[3] = clk_out;
        run = 1'b0;
        for (int c = 3; c <= 5; c++) begin
            cyc();
            pat[5 - c] = clk_out;
            n_chk++; if ({tick, busy} !== 2'b01) $display("FAIL drain c=%0d tick/busy=%b required 01", c, {tick, busy}); else n_pass++;
        end
        n_chk++; if (pat !== 5'b11100) $display("FAIL drain clk_out pattern=%b required 11100", pat); else n_pass++;
        cyc();
        n_chk++; if ({tick, clk_out, busy} !== 3'b000) $display("FAIL drain_end tick/clk_out/busy=%b required 000", {tick, clk_out, busy}); else n_pass++;
        for (int c = 0; c < 4; c++) cyc();
        n_chk++; if ({tick, busy} !== 2'b00) $display("FAIL drain_idle tick/busy=%b required 00", {tick, busy}); else n_pass++;

        run = 1'b1;
        cyc(); cyc();
        run = 1'b0;
        cyc(); cyc();
        run = 1'b1;
        for (int c = 5; c <= 11; c++) begin
            cyc();
            n_chk++; if (tick !== ((c - 1) % 5 == 0)) $display("FAIL rearm c=%0d tick=%b required %b", c, tick, (c - 1) % 5 == 0); else n_pass++;
            n_chk++; if (busy !== 1'b1) $display("FAIL rearm c=%0d busy=%b required 1", c, busy); else n_pass++;
        end
        to_idle();
    endtask

    task automatic test_n1_n2();
        int cnt;
        load_idle(1);
        run = 1'b1;
        cnt = 0;
        for (int c = 1; c <= 10; c++) begin
            cyc();
            cnt += int'(tick);
            n_chk++; if ({tick, clk_out} !== 2'b11) $display("FAIL n1 c=%0d tick/clk_out=%b required 11", c, {tick, clk_out}); else n_pass++;
        end
        n_chk++; if (cnt !== 10) $display("FAIL n1 counter=%0d required 10", cnt); else n_pass++;
        to_idle();
        load_idle(2);
        run = 1'b1;
        cnt = 0;
        for (int c = 1; c <= 10; c++) begin
            cyc();
            cnt += int'(tick);
            n_chk++; if (tick !== (c % 2 == 1))    $display("FAIL n2 c=%0d tick=%b required %b", c, tick, c % 2 == 1); else n_pass++;
            n_chk++; if (clk_out !== (c % 2 == 1)) $display("FAIL n2 c=%0d clk_out=%b required %b", c, clk_out, c % 2 == 1); else n_pass++;
        end
        n_chk++; if (cnt !== 5) $display("FAIL n2 counter=%0d required 5", cnt); else n_pass++;
        to_idle();
    endtask

    task automatic test_async_reset();
        run = 1'b1;
        cyc();
        dif.div_load = 1'b1; dif.div_val = W'(7);
        cyc();
        dif.div_load = 1'b0;
        n_chk++; if (dif.div_ready !== 1'b0) $display("FAIL arst_pending div_ready=%b required 0", dif.div_ready); else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_chk++; if ({tick, clk_out, busy, dif.div_err} !== 4'b0000) $display("FAIL arst outputs=%b required 0000", {tick, clk_out, busy, dif.div_err}); else n_pass++;
        n_chk++; if (dif.div_ready !== 1'b1) $display("FAIL arst div_ready=%b required 1", dif.div_ready); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int c = 1; c <= 12; c++) begin
            cyc();
            n_chk++; if (tick !== ((c - 1) % 4 == 0)) $display("FAIL arst_run c=%0d tick=%b required %b", c, tick, (c - 1) % 4 == 0); else n_pass++;
        end
        to_idle();
    endtask

    task automatic test_random();
        bit e_tick, e_clk;
        rst_n = 1'b0;
        run = 1'b0;
        #2;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) run = ~run;
            dif.div_load = ($urandom_range(0, 5) == 0);
            dif.div_val  = ($urandom_range(0, 3) == 0) ? W'(0) : W'($urandom_range(1, 9));
            cyc();
            e_tick = m_on && (m_pos == 0);
            e_clk  = m_on && (m_pos < (m_n + 1) / 2);
            n_chk++; if (tick !== e_tick)   $display("FAIL rand i=%0d tick=%b required %b", i, tick, e_tick); else n_pass++;
            n_chk++; if (clk_out !== e_clk) $display("FAIL rand i=%0d clk_out=%b required %b", i, clk_out, e_clk); else n_pass++;
            n_chk++; if (busy !== m_on)     $display("FAIL rand i=%0d busy=%b required %b", i, busy, m_on); else n_pass++;
            n_chk++; if (dif.div_err !== m_err) $display("FAIL rand i=%0d div_err=%b required %b", i, dif.div_err, m_err); else n_pass++;
            n_chk++; if (dif.div_ready !== (m_pq.size() == 0)) $display("FAIL rand i=%0d div_ready=%b required %b", i, dif.div_ready, m_pq.size() == 0); else n_pass++;
        end
        dif.div_load = 1'b0;
        to_idle();
    endtask

    initial begin
        test_reset();
        test_default_run();
        test_update();
        test_zero();
        test_drain();
        test_n1_n2();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
